imem_fetch_port: RTL

IMEM_FETCH_PORT -- requirements
Module: imem_fetch_port

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 26 ++
 rtl/imem_fetch_port.sv | 87 ++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
package imem_pkg;

    localparam int IMEM_ADDR_W      = 32;
    localparam int IMEM_DATA_W      = 32;
    localparam int IMEM_DEPTH_WORDS = 128;
    localparam int IMEM_CNT_W       = 16;

    // Instruction returned on a faulted fetch.
    localparam logic [IMEM_DATA_W-1:0] NOP_WORD = '0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one combinational read port.
module imem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    // No reset on storage: program contents must survive rst_n.
    logic [DATA_W-1:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_port.sv
// Single-entry fetch response stage over imem_array with fault checking,
// program-load port and a delivered-fetch counter.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = IMEM_DATA_W,
    parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
    parameter int CNT_W       = IMEM_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_fault,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    fetch_state_t      state;
    logic [DATA_W-1:0] rdata;
    logic              accept;
    logic              handshake;
    logic              req_bad;
    logic              load_bad;

    // Depth is a power of two, so idx >= DEPTH_WORDS reduces to any set bit above the index field.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
    endfunction

    assign req_bad  = addr_bad(req_addr);
    assign load_bad = addr_bad(load_addr);

    imem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (load_en && !load_bad),
        .waddr (load_addr[IDX_W+1:2]),
        .wdata (load_data),
        .raddr (req_addr[IDX_W+1:2]),
        .rdata (rdata)
    );

    assign rsp_valid = (state == FULL);
    assign req_ready = ((state == EMPTY) || rsp_ready) && !load_en && !flush;
    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            rsp_instr   <= '0;
            rsp_addr    <= '0;
            rsp_fault   <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (handshake) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
            if (flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state     <= FULL;
                rsp_instr <= req_bad ? DATA_W'(NOP_WORD) : rdata;
                rsp_addr  <= req_addr;
                rsp_fault <= req_bad;
            end else if (rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
